// File: rtl/multicycle_core.sv
// Multi-cycle core: instructions are fetched over a req/ack handshake, then decoded, executed
// and written back in separate states against a 32-entry register bank.
module multicycle_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic [DATA_W-1:0] salida,
  output logic              wb_valid,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpHalt  = 6'b111111;
  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnSlt   = 6'b101010;

  typedef enum logic [2:0] {StFetch, StDecode, StExecute, StWriteback, StHalt} state_e;
  state_e state_q, state_d;

  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, salida_q, salida_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] regs_q [32];

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd, dst;
  logic [DATA_W-1:0] imm_ext, alu_res;
  logic [PC_W-1:0]   imm_pc;
  logic              do_wb, beq_taken, wr_en;
  logic              unused_shamt;

  assign opcode       = ir_q[31:26];
  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign rd           = ir_q[15:11];
  assign funct        = ir_q[5:0];
  assign unused_shamt = ^ir_q[10:6];

  // Sign-extend the 16-bit immediate, or truncate it when the target is narrower.
  always_comb begin
    imm_ext = '0;
    for (int i = 0; i < int'(DATA_W); i++) imm_ext[i] = (i < 16) ? ir_q[i % 16] : ir_q[15];
    imm_pc = '0;
    for (int i = 0; i < int'(PC_W); i++) imm_pc[i] = (i < 16) ? ir_q[i % 16] : ir_q[15];
  end

  always_comb begin
    alu_res = '0;
    do_wb   = 1'b0;
    dst     = rd;
    case (opcode)
      OpRtype: begin
        do_wb = 1'b1;
        case (funct)
          FnAdd:   alu_res = a_q + b_q;
          FnSub:   alu_res = a_q - b_q;
          FnAnd:   alu_res = a_q & b_q;
          FnOr:    alu_res = a_q | b_q;
          FnSlt:   alu_res = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
          default: do_wb = 1'b0;
        endcase
      end
      OpAddi: begin
        do_wb   = 1'b1;
        dst     = rt;
        alu_res = a_q + imm_ext;
      end
      default: ;
    endcase
  end

  assign beq_taken = (opcode == OpBeq) && (a_q == b_q);
  assign wr_en     = (state_q == StWriteback) && (dst != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:     if (imem_ack) state_d = StDecode;
      StDecode:    state_d = (opcode == OpHalt) ? StHalt : StExecute;
      StExecute:   state_d = do_wb ? StWriteback : StFetch;
      StWriteback: state_d = StFetch;
      StHalt:      state_d = StHalt;
      default:     state_d = StFetch;
    endcase
  end

  // During reset the FSM already sits in FETCH, so the request is masked until release.
  always_comb begin
    imem_req = 1'b0;
    wb_valid = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      StFetch:     imem_req = !rst;
      StWriteback: wb_valid = 1'b1;
      StHalt:      halted   = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    salida_d = salida_q;
    pc_d     = pc_q;
    unique case (state_q)
      StFetch: if (imem_ack) ir_d = imem_data;
      StDecode: begin
        a_d = regs_q[rs];
        b_d = regs_q[rt];
      end
      StExecute: begin
        alu_d = alu_res;
        // salida is loaded here so it is already valid in the WRITEBACK cycle.
        if (do_wb)          salida_d = alu_res;
        else if (beq_taken) pc_d     = pc_q + PC_W'(1) + imm_pc;
        else                pc_d     = pc_q + PC_W'(1);
      end
      StWriteback: pc_d = pc_q + PC_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      salida_q <= '0;
      pc_q     <= '0;
    end else begin
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      salida_q <= salida_d;
      pc_q     <= pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[dst] <= alu_q;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign salida    = salida_q;

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle successor to the single-cycle top level. It contains the PC, instruction register, control FSM, ALU and a 32-entry register bank. Instructions are fetched from an external instruction memory over a request/acknowledge handshake, and each one is executed over several states. It sits between the instruction memory model and the bench, and exposes the writeback value and the PC for observation.

## Interface
- DATA_W, 32, datapath and register width (8..64)
- PC_W, 5, PC width in word addresses; PC wraps modulo 2^PC_W
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request, held high until acknowledged
- imem_addr  out  PC_W  word address of the fetch; equals pc
- imem_ack  in  1  instruction-memory acknowledge; imem_data valid in the same cycle
- imem_data  in  32  instruction word
- salida  out  DATA_W  last value written back
- wb_valid  out  1  one-cycle pulse when salida updates
- pc  out  PC_W  current PC
- halted  out  1  high once HALT is executed

## Operation
- Instruction fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0], funct [5:0].
- R-type (opcode 000000) funct codes:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR.
  - 101010 SLT: signed compare, result 1 or 0.
  - Destination is rd.
- ADDI (001000): rt = rs + sign-extended imm.
- BEQ (000100): if rs == rt then pc = pc + 1 + sign-extended imm, else pc = pc + 1.
- HALT (111111): enter HALT state.
- Any other opcode, or an unknown R-type funct: NOP, pc = pc + 1, no write.
- Immediates are sign-extended to DATA_W; if DATA_W < 16, the low DATA_W bits are used.
- Arithmetic is modulo 2^DATA_W; overflow is ignored.
- Register 0 always reads 0. A write to register 0 still updates salida and pulses wb_valid, but the register stays 0.
- States and transitions:
  - FETCH: imem_req = 1. When imem_ack = 1, latch imem_data into IR and go to DECODE; otherwise stay.
  - DECODE: read rs and rt into registers A and B. HALT → HALT; otherwise → EXECUTE.
  - EXECUTE: compute the ALU result into register ALUOUT.
    - R-type and ADDI → WRITEBACK.
    - BEQ and NOP update pc → FETCH.
  - WRITEBACK: write ALUOUT to the destination, salida = ALUOUT, wb_valid = 1, pc = pc + 1 → FETCH.
  - HALT: terminal. halted = 1, imem_req = 0. Leaves only via rst.
- imem_ack is ignored outside FETCH.

## Timing
- Reset values: pc = 0, salida = 0, wb_valid = 0, imem_req = 0, halted = 0, all registers 0, state = FETCH. imem_req rises in the first cycle after rst deasserts.
- rst asserted mid-instruction aborts it immediately: no write, and every output returns to its reset value asynchronously.
- Zero-wait memory (ack in the first FETCH cycle):
  - R-type/ADDI: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - BEQ/NOP: 3 cycles.
  - HALT: halted rises 2 cycles after the fetching edge.
- Each cycle of imem_ack low adds exactly one FETCH cycle.
- Register writes take effect at the WRITEBACK edge; the next instruction's DECODE sees the new value, so there are no hazards.
- pc and imem_addr change only on the WRITEBACK edge or the EXECUTE edge for BEQ/NOP. They stay stable while imem_req is high.
- wb_valid is high for exactly the WRITEBACK cycle. salida holds its value until the next writeback.
- BEQ target wraps: pc = 31, imm = 0 with PC_W = 5 gives pc = 0. Backward imm -1 gives a self-loop.

## Test plan
- Reset then ADDI r1,r0,5 with zero-wait memory → wb_valid in cycle 4 after reset release, salida = 5, pc = 1.
- ADDI r1=7, ADDI r2=3, then SUB r3=r1-r2, then SLT r4,r2,r1 → salida = 4, then salida = 1. SLT of -1 vs 1 gives 1 (signed).
- imem_ack held low 3 cycles on the first fetch → imem_req stays high with imem_addr = 0 throughout, and the instruction completes 3 cycles later than in the zero-wait case.
- BEQ r0,r0,+2 at pc = 4 → pc = 7, no wb_valid. BEQ with unequal operands → pc = 5.
- ADDI r0,r0,9 → wb_valid pulses with salida = 9; a later ADD r5,r0,r0 gives salida = 0.
- rst pulsed during EXECUTE of ADDI r1=5 → no write, r1 stays 0, pc = 0. HALT → halted = 1 and imem_req stays 0 for 20 cycles.
